instruction_controller: RTL
===========================

INSTRUCTION_CONTROLLER -- requirements
Module: instruction_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset sampled on the clk rising edge.
REQ-003 SHALL have port in, input, 16 bits: instruction word to be captured.
REQ-004 SHALL have port load, input, 1 bit: instruction register load enable.
REQ-005 SHALL have port s, input, 1 bit: start execution of the held instruction.
REQ-006 SHALL have port w, output, 1 bit: 1 = idle in WAIT and ready for a new instruction.
REQ-007 SHALL have port datapath_in, output, 16 bits: sign-extended imm8 from IR[7:0].
REQ-008 SHALL have ports vsel, write, loada, loadb, asel, bsel, loadc, loads, output, 1 bit each: datapath controls. vsel=1 selects datapath_in, vsel=0 selects C. asel=1 forces ALU A to 0.
REQ-009 SHALL have ports readnum and writenum, output, 3 bits each: register file addresses.
REQ-010 SHALL have ports shift and ALUop, output, 2 bits each: shifter and ALU op codes.

Function
REQ-011 SHALL hold a 16-bit IR that loads `in` on a clk edge with load=1 only while in WAIT; load SHALL be ignored in every other state.
REQ-012 SHALL decode IR fields as follows: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-013 SHALL support these instructions:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{sh}
  - 101/00: ADD Rd,Rn,Rm{sh}
  - 101/01: CMP Rn,Rm{sh}
  - 101/10: AND Rd,Rn,Rm{sh}
  - 101/11: MVN Rd,Rm{sh}
REQ-014 SHALL implement a Moore FSM with states WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG; all outputs SHALL be functions of state and IR only.
REQ-015 SHALL drive all load/write enables to 0, asel=0, bsel=0, vsel=0, shift=0 and ALUop=0 unless a state below sets them otherwise; datapath_in SHALL always equal sign-extended IR[7:0].
REQ-016 In WAIT, SHALL assert w=1, go to DECODE on s=1, and otherwise remain in WAIT.
REQ-017 SHALL treat load=1 and s=1 in the same WAIT cycle as: capture IR and go to DECODE; decode then uses the new IR.
REQ-018 SHALL leave DECODE to the next state by instruction:
  - MOV imm: WRITE_IMM
  - MOV reg and MVN: GET_B
  - ADD, CMP, AND: GET_A
  - any other opcode/op combination: WAIT, with no register or flag writes.
REQ-019 In WRITE_IMM, SHALL drive vsel=1, write=1, writenum=Rn, then go to WAIT.
REQ-020 In GET_A, SHALL drive readnum=Rn, loada=1, then go to GET_B.
REQ-021 In GET_B, SHALL drive readnum=Rm, loadb=1, then go to ALU.
REQ-022 In ALU, SHALL drive shift=sh and bsel=0, plus:
  - MOV reg: asel=1, ALUop=00
  - MVN: asel=1, ALUop=11
  - others: asel=0, ALUop=op
REQ-023 In ALU, SHALL assert loadc=1 and loads=0 for every instruction except CMP; for CMP it SHALL assert loads=1 and loadc=0.
REQ-024 SHALL leave ALU to WAIT for CMP and to WRITE_REG for all other instructions.
REQ-025 In WRITE_REG, SHALL drive vsel=0, write=1, writenum=Rd, then go to WAIT.
REQ-026 SHALL ignore s outside WAIT.
REQ-027 SHALL return w=1 the following number of rising edges after the edge that samples s:
  - MOV imm: 2
  - MOV reg and MVN: 4
  - CMP: 4
  - ADD and AND: 5
  - undefined opcode: 1

Reset
REQ-028 On reset=1 at a clk edge, SHALL set state=WAIT and IR=16'h0000 regardless of state; reset SHALL take priority over load and s.
REQ-029 In the cycle after reset, SHALL drive w=1 with all enables, asel, bsel and vsel at 0; a reset mid-instruction SHALL abort it with no further write or load pulses.

Verification (controller driving the existing datapath)
REQ-030 SHALL verify MOV immediates: load 16'hD007 then s → R0=7 with w=1 after 2 edges; then 16'hD102 → R1=2.
REQ-031 SHALL verify ADD with shift: with R0=7 and R1=2, execute 16'hA148 (ADD R2,R1,R0,LSL#1) → R2=16; w=0 for exactly 5 cycles.
REQ-032 SHALL verify CMP: with R0=7 and R1=2, execute 16'hA900 (CMP R1,R0) → Z_out=0, no register changes, exactly one loads pulse and no write pulse.
REQ-033 SHALL verify MVN and sign extension: execute 16'hB861 (MVN R3,R1) → R3=16'hFFFD; execute 16'hD4FF → R4=16'hFFFF.
REQ-034 SHALL verify the boundaries:
  - load=1 during GET_B leaves IR unchanged.
  - undefined opcode 16'hE000 → DECODE then WAIT, with no writes.
  - reset asserted in GET_A → WAIT next cycle with w=1, and the destination register is unchanged.

Source files
------------

// File: rtl/instruction_controller.sv
// Moore-style instruction controller: captures a 16-bit instruction, decodes it and
// sequences the register-file / ALU datapath controls one state per clock.
module instruction_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [15:0] datapath_in,
    output logic        vsel,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop
);

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_ALU       = 3'd5,
        ST_WRITE_REG = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        INS_MOV_IMM = 3'd0,
        INS_MOV_REG = 3'd1,
        INS_ADD     = 3'd2,
        INS_CMP     = 3'd3,
        INS_AND     = 3'd4,
        INS_MVN     = 3'd5,
        INS_UNDEF   = 3'd6
    } instr_t;

    typedef struct packed {
        logic        w;
        logic [15:0] datapath_in;
        logic        vsel;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic        loadc;
        logic        loads;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  shift;
        logic [1:0]  alu_op;
    } ctrl_t;

    function automatic instr_t classify(input logic [15:0] ir);
        instr_t kind;
        case ({ir[15:13], ir[12:11]})
            5'b110_10: kind = INS_MOV_IMM;
            5'b110_00: kind = INS_MOV_REG;
            5'b101_00: kind = INS_ADD;
            5'b101_01: kind = INS_CMP;
            5'b101_10: kind = INS_AND;
            5'b101_11: kind = INS_MVN;
            default:   kind = INS_UNDEF;
        endcase
        return kind;
    endfunction

    // Control word is a pure function of (state, IR); registering it on the
    // next-state values keeps the outputs glitch-free without adding latency.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] ir);
        ctrl_t  c;
        instr_t kind;
        kind          = classify(ir);
        c             = '0;
        c.datapath_in = {{8{ir[7]}}, ir[7:0]};
        case (st)
            ST_WAIT:      c.w = 1'b1;
            ST_DECODE:    c.w = 1'b0;
            ST_WRITE_IMM: begin
                c.vsel     = 1'b1;
                c.write    = 1'b1;
                c.writenum = ir[10:8];
            end
            ST_GET_A: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            ST_GET_B: begin
                c.readnum = ir[2:0];
                c.loadb   = 1'b1;
            end
            ST_ALU: begin
                c.shift = ir[4:3];
                c.bsel  = 1'b0;
                if (kind == INS_MOV_REG) begin
                    c.asel   = 1'b1;
                    c.alu_op = 2'b00;
                end else if (kind == INS_MVN) begin
                    c.asel   = 1'b1;
                    c.alu_op = 2'b11;
                end else begin
                    c.asel   = 1'b0;
                    c.alu_op = ir[12:11];
                end
                if (kind == INS_CMP) begin
                    c.loads = 1'b1;
                end else begin
                    c.loadc = 1'b1;
                end
            end
            ST_WRITE_REG: begin
                c.vsel     = 1'b0;
                c.write    = 1'b1;
                c.writenum = ir[7:5];
            end
            default:      c.w = 1'b0;
        endcase
        return c;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] ir_r;
    logic [15:0] ir_next_s;
    instr_t      kind_s;
    ctrl_t       ctrl_r;

    assign kind_s = classify(ir_r);

    // Next-state and IR capture logic
    always_comb begin
        state_next_s = state_r;
        ir_next_s    = ir_r;
        case (state_r)
            ST_WAIT: begin
                if (load) begin
                    ir_next_s = in;
                end else begin
                    ir_next_s = ir_r;
                end
                if (s) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DECODE: begin
                case (kind_s)
                    INS_MOV_IMM:              state_next_s = ST_WRITE_IMM;
                    INS_MOV_REG, INS_MVN:     state_next_s = ST_GET_B;
                    INS_ADD, INS_CMP, INS_AND: state_next_s = ST_GET_A;
                    default:                  state_next_s = ST_WAIT;
                endcase
            end
            ST_WRITE_IMM: state_next_s = ST_WAIT;
            ST_GET_A:     state_next_s = ST_GET_B;
            ST_GET_B:     state_next_s = ST_ALU;
            ST_ALU: begin
                if (kind_s == INS_CMP) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: state_next_s = ST_WAIT;
            default:      state_next_s = ST_WAIT;
        endcase
    end

    // State, IR and registered control word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_WAIT;
            ir_r    <= 16'h0000;
            ctrl_r  <= ctrl_for(ST_WAIT, 16'h0000);
        end else begin
            state_r <= state_next_s;
            ir_r    <= ir_next_s;
            ctrl_r  <= ctrl_for(state_next_s, ir_next_s);
        end
    end

    assign w           = ctrl_r.w;
    assign datapath_in = ctrl_r.datapath_in;
    assign vsel        = ctrl_r.vsel;
    assign write       = ctrl_r.write;
    assign loada       = ctrl_r.loada;
    assign loadb       = ctrl_r.loadb;
    assign asel        = ctrl_r.asel;
    assign bsel        = ctrl_r.bsel;
    assign loadc       = ctrl_r.loadc;
    assign loads       = ctrl_r.loads;
    assign readnum     = ctrl_r.readnum;
    assign writenum    = ctrl_r.writenum;
    assign shift       = ctrl_r.shift;
    assign ALUop       = ctrl_r.alu_op;

endmodule
